// File: rtl/mul_controller.sv
// Control FSM for the repeated-addition multiplier datapath: loads A and B, clears P,
// then issues ldp/decb until the datapath reports B==0. Optional abort via MUL_TIMEOUT_EN.
module mul_controller #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             eqz,
  output logic [WIDTH-1:0] data_out,
  output logic             lda,
  output logic             ldb,
  output logic             clrp,
  output logic             ldp,
  output logic             decb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  // state_q is the observable FSM state for checkers.
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             timeout;

`ifdef MUL_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;

  assign timeout = (state_q == ACC) && !eqz && (cnt_q == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == LDB) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end else if (state_q == ACC && !eqz) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err = (state_q == DONE) && err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands are captured only on acceptance so they stay stable for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state_q == IDLE && start) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LDA;
      LDA:     state_d = LDB;
      LDB:     state_d = ACC;
      ACC:     if (eqz || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_out = '0;
    lda      = 1'b0;
    ldb      = 1'b0;
    clrp     = 1'b0;
    ldp      = 1'b0;
    decb     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: busy = 1'b0;
      LDA: begin
        data_out = a_q;
        lda      = 1'b1;
      end
      LDB: begin
        data_out = b_q;
        ldb      = 1'b1;
        clrp     = 1'b1;
      end
      ACC: begin
        data_out = a_q;
        if (!eqz && !timeout) begin
          ldp  = 1'b1;
          decb = 1'b1;
        end
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mul_controller.sv
// Bench for mul_controller: behavioural datapath model, scoreboard of expected
// products/latencies checked on every done pulse. Honours MUL_TIMEOUT_EN.
module tb_mul_controller;

`ifdef MUL_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        eqz;
  logic [15:0] data_out;
  logic        lda, ldb, clrp, ldp, decb, busy, done, err;

  mul_controller #(.WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .eqz(eqz),
    .data_out(data_out), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
    .busy(busy), .done(done), .err(err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // datapath model
  logic [15:0] m_a = '0, m_b = '0, m_p = '0;
  assign eqz = (m_b == 16'd0);
  always @(posedge clk) begin
    if (lda) m_a <= data_out;
    if (ldb) m_b <= data_out;
    else if (decb) m_b <= m_b - 16'd1;
    if (clrp) m_p <= '0;
    else if (ldp) m_p <= m_p + m_a;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard
  logic [15:0] exp_q[$];
  int          exp_lat_q[$];
  logic        exp_err_q[$];
  logic        active = 1'b0;
  int          e0 = 0;
  logic [15:0] cur_a, cur_b;
  int          n_ldp = 0, n_decb = 0, done_cnt = 0;
  int          last_done_cyc = 0, last_gap = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_excl", {31'b0, (lda & ldb) | (lda & ldp) | (ldb & ldp) | (clrp & ~ldb)}, 0);
      if (active && !done) begin
        if (cyc - e0 == 0) begin
          check("lda", lda, 1);
          check("bus_a", data_out, cur_a);
        end else if (cyc - e0 == 1) begin
          check("ldb_clrp", {ldb, clrp}, 2'b11);
          check("bus_b", data_out, cur_b);
        end else begin
          check("bus_acc", data_out, cur_a);
        end
        if (ldp) n_ldp++;
        if (decb) n_decb++;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          int   lat, n;
          logic e;
          logic [15:0] p;
          p   = exp_q.pop_front();
          lat = exp_lat_q.pop_front();
          e   = exp_err_q.pop_front();
          n   = lat - 3;
          check("product", m_p, p);
          check("latency", cyc - e0, lat);
          check("err", err, e);
          check("ldp_count", n_ldp, n);
          check("decb_count", n_decb, n);
          check("busy_done", busy, 1);
        end
        active = 1'b0;
      end else if (!busy && start) begin
        int          n;
        logic [31:0] prod;
        n = (op_b > TMO) ? TMO : int'(op_b);
        prod = 32'(op_a) * 32'(n);
        active = 1'b1;
        e0 = cyc + 1;
        last_gap = e0 - last_done_cyc;
        cur_a = op_a;
        cur_b = op_b;
        n_ldp = 0;
        n_decb = 0;
        exp_q.push_back(prod[15:0]);
        exp_lat_q.push_back(n + 3);
        exp_err_q.push_back(op_b > TMO);
      end
    end
  end

  // driver tasks
  task automatic wait_done(input int limit);
    int c0;
    logic seen;
    c0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != c0) seen = 1'b1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk);
    #2;
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(200);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"}, {data_out, lda, ldb, clrp, ldp, decb, busy, done, err}, 0);
    check({tag, "_state"}, dut.state_q, 0);
    check({tag, "_a_q"}, dut.a_q, 0);
    check({tag, "_b_q"}, dut.b_q, 0);
  endtask

  initial begin
    int c0;
    logic hit;
    // reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    run_op(16'd7, 16'd5);
    run_op(16'd1234, 16'd0);

    // start during ACC with new operands is ignored
    @(posedge clk);
    #2;
    op_a = 16'd7; op_b = 16'd5; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    op_a = 16'd9; op_b = 16'd3; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(200);
    repeat (3) @(negedge clk);
    #1;
    check("ignored_start", {31'b0, active}, 0);
    check("sb_after_ignore", exp_q.size(), 0);

    // start held: back-to-back operations
    @(posedge clk);
    #2;
    op_a = 16'd3; op_b = 16'd4; start = 1'b1;
    @(posedge clk);
    #2;
    op_a = 16'd5; op_b = 16'd6;
    wait_done(200);
    wait_done(200);
    check("held_restart_gap", last_gap, 2);
    @(posedge clk);
    #2;
    start = 1'b0;

    run_op(16'hFFFF, 16'd2);
    run_op(16'd0, 16'd4);
    run_op(16'd3, 16'd10);
    for (int i = 0; i < 4; i++) run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 12)));

    // reset mid-ACC: immediate abort, no done
    @(posedge clk);
    #2;
    op_a = 16'd7; op_b = 16'd5; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (ldp) hit = 1'b1;
    end
    check("reached_acc", hit, 1);
    c0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    exp_lat_q.delete();
    exp_err_q.delete();
    active = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("no_done_after_reset", done_cnt, c0);
    run_op(16'd6, 16'd3);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
